// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the bit-serial adder. The ovf signal exists only when
// SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
    input  ovf,
`endif
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
    output ovf,
`endif
    output busy, done, sum, cout
  );

endinterface

// File: rtl/full_adder.sv
// Existing 1-bit full adder cell; the serial adder evaluates one bit position per clock with it.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder plus a carry register, LSB first, done pulse after WIDTH steps.
// Optional signed-overflow output enabled with SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_sum;
  logic             fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // The A register doubles as the sum shift register: each step consumes its LSB
  // and fills its MSB with the new sum bit, so after WIDTH steps it holds the result.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = {fa_sum, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = fa_cout;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          sum_d   = {fa_sum, a_q[WIDTH-1:1]};
          cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
          // On the last step carry_q is the carry into the MSB.
          ovf_d   = carry_q ^ fa_cout;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder (WIDTH=8); overflow cases run when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  localparam int WIDTH = 8;
  localparam int MAX_WAIT = 20;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one addition and return at the negedge where done is seen (or the wait expires).
  task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic icin,
                        output int lat, output logic busy_first);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ia;
    bus.b     = ib;
    bus.cin   = icin;
    @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b0;
    busy_first = bus.busy;
    lat = 0;
    while (bus.done !== 1'b1 && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 8'h00 || bus.cout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_state: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0",
               bus.busy, bus.done, bus.sum, bus.cout);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (bus.ovf !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_ovf: got %b required 0", bus.ovf);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int   lat;
    logic bf;
    run_op(8'h3C, 8'h5A, 1'b0, lat, bf);
    checks++;
    if (bf !== 1'b1) begin
      fails++;
      $display("[TB] FAIL basic_busy: got %b required 1", bf);
    end
    checks++;
    if (lat != WIDTH) begin
      fails++;
      $display("[TB] FAIL basic_latency: got %0d required %0d", lat, WIDTH);
    end
    checks++;
    if (bus.sum !== 8'h96 || bus.cout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_result: got sum=%h cout=%b required 96 0", bus.sum, bus.cout);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_done_pulse: got done=%b busy=%b required 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_carry();
    int   lat;
    logic bf;
    run_op(8'hFF, 8'h01, 1'b0, lat, bf);
    checks++;
    if (bus.sum !== 8'h00 || bus.cout !== 1'b1) begin
      fails++;
      $display("[TB] FAIL carry_ff_01: got sum=%h cout=%b required 00 1", bus.sum, bus.cout);
    end
    run_op(8'hFF, 8'hFF, 1'b1, lat, bf);
    checks++;
    if (bus.sum !== 8'hFF || bus.cout !== 1'b1) begin
      fails++;
      $display("[TB] FAIL carry_ff_ff_1: got sum=%h cout=%b required ff 1", bus.sum, bus.cout);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.sum !== 8'hFF || bus.cout !== 1'b1 || bus.done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL hold_idle: got sum=%h cout=%b done=%b required ff 1 0",
               bus.sum, bus.cout, bus.done);
    end
  endtask

  task automatic test_start_ignored();
    int               pulses;
    logic [WIDTH-1:0] s;
    logic             c;
    pulses = 0;
    s = '0;
    c = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h01;
    bus.b     = 8'h02;
    bus.cin   = 1'b0;
    @(posedge clk);
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      if (j == 3) begin
        bus.a   = 8'h11;
        bus.b   = 8'hFF;
        bus.cin = 1'b1;
      end
      if (j == 5) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        pulses++;
        s = bus.sum;
        c = bus.cout;
      end
    end
    checks++;
    if (pulses != 1) begin
      fails++;
      $display("[TB] FAIL ignore_pulses: got %0d done pulses required 1", pulses);
    end
    checks++;
    if (s !== 8'h03 || c !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ignore_result: got sum=%h cout=%b required 03 0", s, c);
    end
  endtask

  task automatic test_reset_mid_run();
    int   seen;
    int   lat;
    logic bf;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h3C;
    bus.b     = 8'h5A;
    bus.cin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 8'h00 || bus.cout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_state: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0",
               bus.busy, bus.done, bus.sum, bus.cout);
    end
    seen = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      fails++;
      $display("[TB] FAIL abort_no_done: got %0d active cycles required 0", seen);
    end
    run_op(8'h80, 8'h90, 1'b1, lat, bf);
    checks++;
    if (lat != WIDTH || bus.sum !== 8'h11 || bus.cout !== 1'b1) begin
      fails++;
      $display("[TB] FAIL abort_restart: got lat=%0d sum=%h cout=%b required 8 11 1",
               lat, bus.sum, bus.cout);
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic bf;
    run_op(8'h12, 8'h34, 1'b1, lat, bf);
    checks++;
    if (bus.sum !== 8'h47 || bus.cout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_first: got sum=%h cout=%b required 47 0", bus.sum, bus.cout);
    end
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    bus.cin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.sum !== 8'h47) begin
      fails++;
      $display("[TB] FAIL b2b_no_idle: got busy=%b done=%b sum=%h required 1 0 47",
               bus.busy, bus.done, bus.sum);
    end
    lat = 0;
    while (bus.done !== 1'b1 && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != WIDTH || bus.sum !== 8'h30 || bus.cout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_second: got lat=%0d sum=%h cout=%b required 8 30 0",
               lat, bus.sum, bus.cout);
    end
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_overflow();
    int   lat;
    logic bf;
    run_op(8'h7F, 8'h01, 1'b0, lat, bf);
    checks++;
    if (bus.sum !== 8'h80 || bus.ovf !== 1'b1 || bus.cout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ovf_7f_01: got sum=%h ovf=%b cout=%b required 80 1 0",
               bus.sum, bus.ovf, bus.cout);
    end
    run_op(8'hFF, 8'h01, 1'b0, lat, bf);
    checks++;
    if (bus.sum !== 8'h00 || bus.ovf !== 1'b0 || bus.cout !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ovf_ff_01: got sum=%h ovf=%b cout=%b required 00 0 1",
               bus.sum, bus.ovf, bus.cout);
    end
  endtask
`endif

  initial begin
    checks    = 0;
    fails     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SERIAL_ADDER_OVF_EN
    test_overflow();
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
